// File: rtl/memaddr_event_receiver_pkg.sv
// Shared widths, overflow-marker id and receiver state encoding for the
// diagnosis event path.
package memaddr_event_receiver_pkg;

  localparam int DIAGNOSIS_EV_ID_WIDTH     = 8;
  localparam int DIAGNOSIS_TIMESTAMP_WIDTH = 16;

  localparam logic [DIAGNOSIS_EV_ID_WIDTH-1:0] DIAGNOSIS_OVF_EVENT_ID = '1;

  typedef enum logic {
    ST_RUN         = 1'b0,
    ST_OVF_PENDING = 1'b1
  } rx_state_e;

endpackage

// File: rtl/memaddr_event_receiver_fifo.sv
// First-word-fall-through synchronous FIFO; head_data reads as zero when empty.
// Caller must only pop when non-empty and only push when not full (or popping).
module diag_event_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = (count_q != '0) ? mem[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/memaddr_event_receiver.sv
// Buffers comparator event pulses and forwards them in order over valid/ready;
// lost events are counted and reported in-band by an overflow marker entry.
module memaddr_event_receiver
  import memaddr_event_receiver_pkg::*;
#(
  parameter int                        EVENT_ID_WIDTH  = DIAGNOSIS_EV_ID_WIDTH,
  parameter int                        TIMESTAMP_WIDTH = DIAGNOSIS_TIMESTAMP_WIDTH,
  parameter int                        FIFO_DEPTH      = 4,
  parameter int                        DROP_CNT_WIDTH  = 8,
  parameter logic [EVENT_ID_WIDTH-1:0] OVF_EVENT_ID    = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       diag_sys_enabled,
  input  logic                       ev_valid,
  input  logic [EVENT_ID_WIDTH-1:0]  ev_id,
  input  logic [TIMESTAMP_WIDTH-1:0] ev_time,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EVENT_ID_WIDTH-1:0]  out_id,
  output logic [TIMESTAMP_WIDTH-1:0] out_time,
  output logic                       overflow
);

  localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int              W        = EVENT_ID_WIDTH + TIMESTAMP_WIDTH;
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

  rx_state_e                 state_q, state_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d, drop_cnt_inc;
  logic                      accept, pop, room, push;
  logic [W-1:0]              push_data, head_data;
  logic [CW-1:0]             count;

  assign accept       = ev_valid & diag_sys_enabled;
  assign pop          = out_valid & out_ready;
  assign room         = (count != FULL_CNT) | pop;
  assign drop_cnt_inc = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;

  // While a marker is owed it takes the first free slot ahead of any new event.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    push_data  = {ev_id, ev_time};
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (room) begin
            push = 1'b1;
          end else begin
            drop_cnt_d = drop_cnt_inc;
            state_d    = ST_OVF_PENDING;
          end
        end
      end
      ST_OVF_PENDING: begin
        if (room) begin
          push      = 1'b1;
          push_data = {OVF_EVENT_ID, TIMESTAMP_WIDTH'(drop_cnt_q)};
          if (accept) begin
            drop_cnt_d = DROP_CNT_WIDTH'(1);
          end else begin
            drop_cnt_d = '0;
            state_d    = ST_RUN;
          end
        end else if (accept) begin
          drop_cnt_d = drop_cnt_inc;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  diag_event_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign out_id    = head_data[W-1:TIMESTAMP_WIDTH];
  assign out_time  = head_data[TIMESTAMP_WIDTH-1:0];
  assign overflow  = (state_q == ST_OVF_PENDING);

endmodule

// File: tb/tb_memaddr_event_receiver.sv
// Scoreboard bench: a queue-level reference model predicts every emitted entry;
// a negedge monitor compares the DUT head against it.
module tb_memaddr_event_receiver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        diag_sys_enabled = 1'b1;
  logic        ev_valid = 1'b0;
  logic [7:0]  ev_id = '0;
  logic [15:0] ev_time = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_id;
  logic [15:0] out_time;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  logic [23:0] mq[$];
  logic [23:0] sb[$];
  logic [23:0] got[$];
  logic [23:0] exp_list[$];
  bit          pend = 1'b0;
  int          drops = 0;

  memaddr_event_receiver #(
    .EVENT_ID_WIDTH  (8),
    .TIMESTAMP_WIDTH (16),
    .FIFO_DEPTH      (DEPTH),
    .DROP_CNT_WIDTH  (8),
    .OVF_EVENT_ID    (8'hFF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .diag_sys_enabled (diag_sys_enabled),
    .ev_valid         (ev_valid),
    .ev_id            (ev_id),
    .ev_time          (ev_time),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_id           (out_id),
    .out_time         (out_time),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, marker owed as a flag plus a plain drop count.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      sb.delete();
      pend  = 1'b0;
      drops = 0;
    end else begin
      bit acc;
      acc = ev_valid && diag_sys_enabled;
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (mq.size() < DEPTH && pend) begin
        mq.push_back({8'hFF, 16'(drops)});
        sb.push_back({8'hFF, 16'(drops)});
        if (acc) drops = 1;
        else begin
          drops = 0;
          pend  = 1'b0;
        end
      end else if (mq.size() < DEPTH && acc) begin
        mq.push_back({ev_id, ev_time});
        sb.push_back({ev_id, ev_time});
      end else if (acc) begin
        drops = (drops < 255) ? drops + 1 : 255;
        pend  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("overflow", 32'(overflow), 32'(pend));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'({out_id, out_time}), 32'h0);
        end else begin
          chk("head", 32'({out_id, out_time}), 32'(sb[0]));
          if (out_ready) begin
            got.push_back({out_id, out_time});
            void'(sb.pop_front());
          end
        end
      end else begin
        chk("empty_head_zero", 32'({out_id, out_time}), 32'h0);
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] id, input logic [15:0] t);
    ev_valid = v;
    ev_id    = id;
    ev_time  = t;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 16'h0);
  endtask

  task automatic expect_got(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(exp_list.size()));
    for (int i = 0; i < got.size() && i < exp_list.size(); i++)
      chk({name, "_entry"}, 32'(got[i]), 32'(exp_list[i]));
    got.delete();
  endtask

  task automatic fill4(input logic [7:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, base + 8'(i), 16'(base) + 16'(i));
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_id", 32'(out_id), 32'h0);
    chk("rst_out_time", 32'(out_time), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // 1: single event, one-cycle latency, one cycle of valid
    out_ready = 1'b1;
    got.delete();
    step(1'b1, 8'h03, 16'd100);
    chk("s1_valid_rise", 32'(out_valid), 32'h1);
    chk("s1_id_time", 32'({out_id, out_time}), 32'h030064);
    step(1'b0, 8'h00, 16'h0);
    chk("s1_valid_fall", 32'(out_valid), 32'h0);
    idle(2);
    exp_list = '{24'h030064};
    expect_got("s1");

    // 2: overflow and marker
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'(i), 16'(9 + i));
      if (i == 4) chk("s2_no_ovf_yet", 32'(overflow), 32'h0);
      if (i == 5) chk("s2_ovf_after5", 32'(overflow), 32'h1);
    end
    out_ready = 1'b1;
    idle(8);
    chk("s2_ovf_cleared", 32'(overflow), 32'h0);
    exp_list = '{24'h01000A, 24'h02000B, 24'h03000C, 24'h04000D, 24'hFF0002};
    expect_got("s2");

    // 3: full, simultaneous push and pop
    fill4(8'h20);
    out_ready = 1'b1;
    step(1'b1, 8'h09, 16'h0009);
    chk("s3_no_ovf", 32'(overflow), 32'h0);
    idle(8);
    exp_list = '{24'h200020, 24'h210021, 24'h220022, 24'h230023, 24'h090009};
    expect_got("s3");

    // 4: saturating drop count
    fill4(8'h40);
    for (int i = 0; i < 300; i++) step(1'b1, 8'h55, 16'(i));
    out_ready = 1'b1;
    idle(8);
    exp_list = '{24'h400040, 24'h410041, 24'h420042, 24'h430043, 24'hFF00FF};
    expect_got("s4");

    // 5: event collides with marker insertion
    fill4(8'h30);
    step(1'b1, 8'h50, 16'h1);
    step(1'b1, 8'h51, 16'h2);
    out_ready = 1'b1;
    step(1'b1, 8'h07, 16'h7);
    chk("s5_ovf_held", 32'(overflow), 32'h1);
    idle(8);
    chk("s5_ovf_cleared", 32'(overflow), 32'h0);
    exp_list = '{24'h300030, 24'h310031, 24'h320032, 24'h330033, 24'hFF0002, 24'hFF0001};
    expect_got("s5");

    // 6: enable low, then reset with entries queued
    diag_sys_enabled = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 16'h60);
    idle(3);
    chk("s6_dis_ovf", 32'(overflow), 32'h0);
    exp_list = {};
    expect_got("s6a");
    diag_sys_enabled = 1'b1;
    out_ready = 1'b0;
    step(1'b1, 8'h61, 16'h61);
    step(1'b1, 8'h62, 16'h62);
    chk("s6_queued", 32'(out_valid), 32'h1);
    rst = 1'b0;
    #1;
    chk("s6_arst_valid", 32'(out_valid), 32'h0);
    chk("s6_arst_id", 32'(out_id), 32'h0);
    chk("s6_arst_time", 32'(out_time), 32'h0);
    chk("s6_arst_ovf", 32'(overflow), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    idle(3);
    exp_list = {};
    expect_got("s6b");

    // Randomized traffic with bursts of stalls; the scoreboard checks every cycle.
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 0) out_ready = ($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 3) == 0) out_ready = ~out_ready;
      diag_sys_enabled = ($urandom_range(0, 9) != 0);
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 16'($urandom));
    end
    diag_sys_enabled = 1'b1;
    out_ready = 1'b1;
    idle(12);
    chk("rand_drained", 32'(sb.size()), 32'h0);
    chk("rand_ovf_clear", 32'(overflow), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memaddr_event_receiver.md
Name: memaddr_event_receiver

Overview:
- Consumer end of the monitor event interface (ev_valid / ev_id / ev_time) driven by the memory-address comparator.
- Captures single-cycle event pulses into a small FIFO, since the interface has no backpressure.
- Forwards events in order over a valid/ready handshake toward the diagnosis packetizer.
- On FIFO overflow, counts lost events and inserts an in-band overflow marker event once space frees.

Parameters:
- EVENT_ID_WIDTH, `DIAGNOSIS_EV_ID_WIDTH, event id width.
- TIMESTAMP_WIDTH, `DIAGNOSIS_TIMESTAMP_WIDTH, timestamp width.
- FIFO_DEPTH, 4, entries; power of two, ≥2.
- DROP_CNT_WIDTH, 8, saturating lost-event counter width; must be ≤ TIMESTAMP_WIDTH.
- OVF_EVENT_ID, all ones, id carried by the overflow marker entry.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-low reset.
- diag_sys_enabled  in  1  capture enable.
- ev_valid  in  1  single-cycle event qualifier from monitor.
- ev_id  in  EVENT_ID_WIDTH  event id.
- ev_time  in  TIMESTAMP_WIDTH  event timestamp.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_id  out  EVENT_ID_WIDTH  head id.
- out_time  out  TIMESTAMP_WIDTH  head timestamp, or drop count for a marker.
- overflow  out  1  high while lost events are pending report.

Behaviour:
- Reset (rst low, asynchronous): FIFO count 0, pointers 0, drop_cnt 0, state RUN. Outputs out_valid=0, out_id=0, out_time=0, overflow=0. Storage array is not reset.
- Capture: accept = ev_valid && diag_sys_enabled.
  - Accepted event is written at the clock edge.
  - out_valid rises the next cycle (1-cycle latency). No combinational path from ev_* to out_*.
- FIFO is first-word-fall-through.
  - out_id/out_time show the head entry; both are 0 when empty.
  - out_valid = (count != 0).
  - Pop when out_valid && out_ready.
- One write per cycle. Write is allowed if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Full + push + pop: the push is accepted and count stays at DEPTH.
- Drop: an accepted event that cannot be written is discarded.
  - drop_cnt increments, saturating at 2^DROP_CNT_WIDTH-1.
  - State moves to OVF_PENDING.
- State machine:
  - RUN: normal writes. Drop → OVF_PENDING.
  - OVF_PENDING: the first cycle a write is allowed, the marker {OVF_EVENT_ID, drop_cnt zero-extended} is written instead of any incoming event.
    - A same-cycle incoming accepted event is dropped, and drop_cnt is reloaded to 1 (stay in OVF_PENDING).
    - Otherwise drop_cnt is cleared → RUN.
    - Further drops while waiting keep incrementing drop_cnt.
- overflow = (state == OVF_PENDING), registered.
- diag_sys_enabled low: no captures and no drops counted. FIFO keeps draining. A pending marker is still inserted.
- Pointer wrap: modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1 to distinguish full from empty.
- out_valid, once high, stays high with stable head data until popped; events are never reordered.

Decomposition:
- diagnosis_config package/header: EV_ID/TIMESTAMP width defaults, an OVF_EVENT_ID default constant, and a state encoding localparam (RUN=0, OVF_PENDING=1).
- One sub-module, diag_event_fifo: generic FWFT synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push/pop/data/count.
  - It uses the same active-low async reset.
- The receiver holds the drop counter, state machine and marker mux.

Test Plan:
Bench configuration for all scenarios: EVENT_ID_WIDTH=8, TIMESTAMP_WIDTH=16, FIFO_DEPTH=4, DROP_CNT_WIDTH=8, OVF_EVENT_ID=8'hFF.
1. Reset and single event.
   - Stimulus: assert rst low, release; pulse ev_valid with id=8'h03, time=16'd100; out_ready=1.
   - Required: after reset all outputs 0. out_valid high exactly one cycle, starting the cycle after the pulse, with out_id=03, out_time=100.
2. Overflow and marker.
   - Stimulus: out_ready=0; send 6 events, ids 1..6 at times 10..15. Then out_ready=1.
   - Required: overflow=1 after the 5th event. Output order is ids 1,2,3,4, then marker FF with time=2. overflow=0 after the marker is written. Ids 5 and 6 never appear.
3. Full with simultaneous push and pop.
   - Stimulus: fill 4 entries with out_ready=0. In one cycle, raise out_ready and pulse event id 9.
   - Required: no drop, overflow stays 0, count stays 4, id 9 is emitted last.
4. Saturating drop count.
   - Stimulus: hold FIFO full and send 300 events; then drain.
   - Required: marker time=16'd255.
5. Marker collision.
   - Stimulus: in OVF_PENDING, pulse an event (id 7) in the same cycle the first slot frees.
   - Required: marker carries the old count. overflow stays 1. A second marker with time=1 follows.
6. Enable low and reset mid-operation.
   - Stimulus: with diag_sys_enabled=0, pulse 3 events. Then assert rst with 2 entries queued.
   - Required: the 3 events give no output and no drops. After rst is asserted, out_valid=0, out_id=0, out_time=0 and overflow=0 immediately, with no clock edge.
